// File: rtl/output_port_arbiter.sv
// Wormhole allocator for one router output port: round-robin over packet heads,
// lock to the winner until its tail, forced release after MAX_PKT_LEN flits.
module output_port_arbiter #(
    parameter int NUM_PORTS   = 5,
    parameter int FLIT_W      = 32,
    parameter int MAX_PKT_LEN = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_PORTS-1:0]          i_req,
    input  logic [NUM_PORTS*FLIT_W-1:0]   i_flit,
    input  logic                          i_downstream_on,
    output logic [NUM_PORTS-1:0]          o_pop,
    output logic [FLIT_W-1:0]             o_flit,
    output logic                          o_valid,
    output logic                          o_busy,
    output logic [$clog2(NUM_PORTS)-1:0]  o_owner,
    output logic                          o_err_len,
    output logic                          o_drop
);
    localparam int PW = $clog2(NUM_PORTS);
    localparam int LW = $clog2(MAX_PKT_LEN + 1);

    typedef enum logic {IDLE, LOCKED} state_t;

    // Handshake: o_pop[p] means buffer p's front flit is consumed at the coming edge;
    // it is only raised when i_req[p] is high and never for more than one port.
    state_t            state_q, state_d;
    logic [PW-1:0]     rr_q, rr_d;
    logic [PW-1:0]     owner_q, owner_d;
    logic [LW-1:0]     len_q, len_d;
    logic [FLIT_W-1:0] flit_q, flit_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic              drop_q, drop_d;
    logic [NUM_PORTS-1:0] pop;

    logic [FLIT_W-1:0] flits [NUM_PORTS];
    logic [1:0]        ftype [NUM_PORTS];

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
        assign flits[g] = i_flit[g*FLIT_W +: FLIT_W];
        assign ftype[g] = flits[g][FLIT_W-1 -: 2];
    end

    logic [PW-1:0] next_owner;
    logic [LW-1:0] len_inc;
    assign next_owner = (owner_q == PW'(NUM_PORTS - 1)) ? '0 : owner_q + PW'(1);
    assign len_inc    = len_q + LW'(1);

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        len_d   = len_q;
        flit_d  = flit_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        drop_d  = 1'b0;
        pop     = '0;
        case (state_q)
            IDLE: begin : idle_arb
                logic          found;
                logic          orphan;
                logic [PW-1:0] win;
                logic [PW-1:0] cand;
                int            idx;
                found  = 1'b0;
                orphan = 1'b0;
                win    = '0;
                cand   = '0;
                idx    = 0;
                // Heads only compete; scan starts at the round-robin pointer.
                for (int i = 0; i < NUM_PORTS; i++) begin
                    idx = int'(rr_q) + i;
                    if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
                    cand = PW'(idx);
                    if (!found && i_req[cand] && ftype[cand][1]) begin
                        found = 1'b1;
                        win   = cand;
                    end
                end
                if (found) begin
                    state_d = LOCKED;
                    owner_d = win;
                    len_d   = '0;
                end else begin
                    // Body/tail with no owning packet: discard the lowest-index one.
                    for (int p = 0; p < NUM_PORTS; p++) begin
                        if (!orphan && i_req[p] && !ftype[p][1]) begin
                            orphan = 1'b1;
                            pop[p] = 1'b1;
                        end
                    end
                    drop_d = orphan;
                end
            end
            LOCKED: begin
                if (i_req[owner_q] && i_downstream_on) begin
                    pop[owner_q] = 1'b1;
                    flit_d       = flits[owner_q];
                    valid_d      = 1'b1;
                    len_d        = len_inc;
                    if (ftype[owner_q][0]) begin
                        state_d = IDLE;
                        rr_d    = next_owner;
                        len_d   = '0;
                    end else if (len_inc == LW'(MAX_PKT_LEN)) begin
                        state_d = IDLE;
                        rr_d    = next_owner;
                        len_d   = '0;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rr_q    <= '0;
            owner_q <= '0;
            len_q   <= '0;
            flit_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            len_q   <= len_d;
            flit_q  <= flit_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
        end
    end

    // Pop is combinational; hold it off while reset is asserted.
    assign o_pop     = reset_n ? pop : '0;
    assign o_flit    = flit_q;
    assign o_valid   = valid_q;
    assign o_busy    = (state_q == LOCKED);
    assign o_owner   = owner_q;
    assign o_err_len = err_q;
    assign o_drop    = drop_q;

endmodule

// File: tb/tb_output_port_arbiter.sv
// Directed bench for output_port_arbiter: per-port input buffers are modelled as
// queues advanced by o_pop; outputs are checked cycle by cycle against hand values.
module tb_output_port_arbiter;
    localparam int NP = 5;
    localparam int FW = 32;
    localparam int ML = 16;

    logic             clk;
    logic             reset_n;
    logic [NP-1:0]    i_req;
    logic [NP*FW-1:0] i_flit;
    logic             i_downstream_on;
    logic [NP-1:0]    o_pop;
    logic [FW-1:0]    o_flit;
    logic             o_valid;
    logic             o_busy;
    logic [2:0]       o_owner;
    logic             o_err_len;
    logic             o_drop;

    output_port_arbiter #(.NUM_PORTS(NP), .FLIT_W(FW), .MAX_PKT_LEN(ML)) dut (
        .clk(clk), .reset_n(reset_n), .i_req(i_req), .i_flit(i_flit),
        .i_downstream_on(i_downstream_on), .o_pop(o_pop), .o_flit(o_flit),
        .o_valid(o_valid), .o_busy(o_busy), .o_owner(o_owner),
        .o_err_len(o_err_len), .o_drop(o_drop)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [FW-1:0] bq [NP][$];
    logic [FW-1:0] exp_q [$];
    logic [NP-1:0] pop_s;
    int total = 0;
    int bad   = 0;

    function automatic logic [FW-1:0] mk(input logic [1:0] t, input int v);
        return {t, 30'(v)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // driver tasks
    task automatic drive();
        for (int p = 0; p < NP; p++) begin
            i_req[p] = (bq[p].size() > 0);
            i_flit[p*FW +: FW] = (bq[p].size() > 0) ? bq[p][0] : '0;
        end
    endtask

    task automatic settle();
        drive();
        #1;
    endtask

    task automatic tick();
        pop_s = o_pop;
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++)
            if (pop_s[p] && bq[p].size() > 0) void'(bq[p].pop_front());
        settle();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        i_downstream_on = 1'b1;
        for (int p = 0; p < NP; p++) bq[p].delete();
        settle();
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        #1;
    endtask

    initial begin : main
        int gs [5];
        logic [FW-1:0] fs [5];

        i_req = '0;
        i_flit = '0;
        do_reset();
        reset_n = 1'b0;
        #1;
        check("rst_valid", o_valid, 0);
        check("rst_busy", o_busy, 0);
        check("rst_flit", o_flit, 0);
        check("rst_pop", o_pop, 0);
        check("rst_err_drop", {o_err_len, o_drop}, 0);
        do_reset();

        // 1: port 2 sends H,B,B,T
        bq[2].push_back(mk(2'b10, 21));
        bq[2].push_back(mk(2'b00, 22));
        bq[2].push_back(mk(2'b00, 23));
        bq[2].push_back(mk(2'b01, 24));
        settle();
        check("t1_c1_pop", o_pop, 0);
        check("t1_c1_busy", o_busy, 0);
        tick();
        check("t1_c2_busy", o_busy, 1);
        check("t1_c2_owner", o_owner, 2);
        check("t1_c2_pop", o_pop, 5'b00100);
        check("t1_c2_valid", o_valid, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t1_valid", o_valid, 1);
            check("t1_flit", o_flit, mk(k == 0 ? 2'b10 : (k == 3 ? 2'b01 : 2'b00), 21 + k));
            check("t1_busy", o_busy, (k < 3) ? 1 : 0);
            check("t1_pop", o_pop, (k < 3) ? 5'b00100 : 5'b0);
        end
        tick();
        check("t1_c7_valid", o_valid, 0);
        check("t1_c7_hold", o_flit, mk(2'b01, 24));

        // 2: ports 0,1,3 hold HEAD+TAIL, rr from 0
        do_reset();
        bq[0].push_back(mk(2'b11, 1));
        bq[1].push_back(mk(2'b11, 2));
        bq[3].push_back(mk(2'b11, 3));
        bq[0].push_back(mk(2'b11, 4));
        bq[1].push_back(mk(2'b11, 5));
        gs = '{0, 1, 3, 0, 1};
        for (int i = 0; i < 5; i++) fs[i] = mk(2'b11, i + 1);
        settle();
        check("t2_c1_busy", o_busy, 0);
        check("t2_c1_pop", o_pop, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_busy", o_busy, 1);
            check("t2_owner", o_owner, gs[i]);
            check("t2_pop", o_pop, 32'(1) << gs[i]);
            tick();
            check("t2_valid", o_valid, 1);
            check("t2_flit", o_flit, fs[i]);
            check("t2_idle", o_busy, 0);
        end

        // 3: port 1 mid-packet, downstream off for 3 cycles
        bq[1].push_back(mk(2'b10, 30));
        for (int k = 1; k <= 3; k++) bq[1].push_back(mk(2'b00, 30 + k));
        bq[1].push_back(mk(2'b01, 34));
        settle();
        tick();
        check("t3_owner", o_owner, 1);
        check("t3_pop_h", o_pop, 5'b00010);
        tick();
        check("t3_flit_h", o_flit, mk(2'b10, 30));
        check("t3_pop_b1", o_pop, 5'b00010);
        tick();
        i_downstream_on = 1'b0;
        #1;
        check("t3_off_valid_b1", o_valid, 1);
        check("t3_off_flit_b1", o_flit, mk(2'b00, 31));
        check("t3_off_pop", o_pop, 0);
        for (int k = 0; k < 2; k++) begin
            tick();
            check("t3_stall_valid", o_valid, 0);
            check("t3_stall_flit", o_flit, mk(2'b00, 31));
            check("t3_stall_pop", o_pop, 0);
            check("t3_stall_busy", o_busy, 1);
        end
        tick();
        i_downstream_on = 1'b1;
        #1;
        check("t3_resume_valid", o_valid, 0);
        check("t3_resume_pop", o_pop, 5'b00010);
        for (int k = 2; k <= 4; k++) begin
            tick();
            check("t3_valid", o_valid, 1);
            check("t3_flit", o_flit, mk(k == 4 ? 2'b01 : 2'b00, 30 + k));
        end
        check("t3_end_busy", o_busy, 0);

        // 4: port 4 HEAD + 20 BODY, forced release at 16 flits
        bq[4].push_back(mk(2'b10, 400));
        for (int j = 1; j <= 20; j++) bq[4].push_back(mk(2'b00, 400 + j));
        for (int j = 0; j < ML; j++) exp_q.push_back(mk(j == 0 ? 2'b10 : 2'b00, 400 + j));
        settle();
        for (int k = 0; k < ML; k++) begin
            tick();
            check("t4_pop", o_pop, 5'b10000);
            check("t4_owner", o_owner, 4);
            check("t4_err", o_err_len, 0);
            if (k > 0) begin
                check("t4_valid", o_valid, 1);
                check("t4_flit", o_flit, exp_q.pop_front());
            end
        end
        tick();
        check("t4_last_valid", o_valid, 1);
        check("t4_last_flit", o_flit, exp_q.pop_front());
        check("t4_err_pulse", o_err_len, 1);
        check("t4_rel_busy", o_busy, 0);
        check("t4_orphan_pop", o_pop, 5'b10000);
        check("t4_no_drop_yet", o_drop, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t4_drop", o_drop, 1);
            check("t4_drop_pop", o_pop, 5'b10000);
            check("t4_drop_valid", o_valid, 0);
            check("t4_err_clear", o_err_len, 0);
        end
        tick();
        bq[0].push_back(mk(2'b11, 450));
        settle();
        check("t4_last_drop", o_drop, 1);
        check("t4_arb_pop", o_pop, 0);
        tick();
        check("t4_p0_busy", o_busy, 1);
        check("t4_p0_owner", o_owner, 0);
        check("t4_p0_pop", o_pop, 5'b00001);
        check("t4_p0_drop", o_drop, 0);
        tick();
        check("t4_p0_flit", o_flit, mk(2'b11, 450));

        // 5: orphan BODY/TAIL fronts, no heads anywhere
        bq[0].push_back(mk(2'b00, 500));
        settle();
        check("t5_pop0", o_pop, 5'b00001);
        tick();
        check("t5_drop", o_drop, 1);
        check("t5_valid", o_valid, 0);
        check("t5_busy", o_busy, 0);
        bq[1].push_back(mk(2'b01, 501));
        bq[3].push_back(mk(2'b00, 503));
        settle();
        check("t5_low_first", o_pop, 5'b00010);
        tick();
        check("t5_drop1", o_drop, 1);
        check("t5_pop3", o_pop, 5'b01000);
        tick();
        check("t5_drop3", o_drop, 1);
        check("t5_pop_none", o_pop, 0);
        tick();
        check("t5_drop_end", o_drop, 0);

        // 6: reset while locked mid-packet
        bq[2].push_back(mk(2'b10, 600));
        for (int k = 1; k <= 3; k++) bq[2].push_back(mk(2'b00, 600 + k));
        settle();
        tick();
        check("t6_owner", o_owner, 2);
        tick();
        tick();
        check("t6_mid_busy", o_busy, 1);
        check("t6_mid_flit", o_flit, mk(2'b00, 601));
        #1 reset_n = 1'b0;
        #1;
        check("t6_rst_valid", o_valid, 0);
        check("t6_rst_busy", o_busy, 0);
        check("t6_rst_flit", o_flit, 0);
        check("t6_rst_owner", o_owner, 0);
        check("t6_rst_pop", o_pop, 0);
        do_reset();
        bq[0].push_back(mk(2'b11, 610));
        bq[1].push_back(mk(2'b11, 611));
        bq[2].push_back(mk(2'b10, 612));
        bq[2].push_back(mk(2'b01, 613));
        settle();
        gs = '{0, 1, 2, 0, 0};
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_owner_after", o_owner, gs[i]);
            check("t6_pop_after", o_pop, 32'(1) << gs[i]);
            tick();
            check("t6_flit_after", o_flit, mk(i == 2 ? 2'b10 : 2'b11, 610 + i));
        end
        check("t6_pop_tail", o_pop, 5'b00100);
        tick();
        check("t6_tail", o_flit, mk(2'b01, 613));
        check("t6_end_busy", o_busy, 0);

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
